pipeline_ctrl: RTL

- Central pipeline hazard/stall controller and driver of the enable_*/flush_* inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC write enable.
- Resolves four conditions per cycle in fixed priority: dmem wait, imem miss, taken branch/jump, load-use.
- Sequences halt drain and holds the halted state.
- Keeps saturating stall and flush event counters for the cpu tracker.

---
 rtl/data_path_muxs_pkg.sv | 35 +++
 rtl/pipeline_ctrl_sat_counter.sv | 25 ++
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/data_path_muxs_pkg.sv
// Shared datapath select encodings and pipeline controller state type.
// Also carries the load-use compare so every stage decodes it the same way.
package data_path_muxs_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  typedef enum logic {
    SEL_ALU  = 1'b0,
    SEL_DMEM = 1'b1
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    DEST_RT = 2'd0,
    DEST_RD = 2'd1,
    DEST_RA = 2'd2
  } reg_dest_t;

  // A load writing $zero never creates a real dependency.
  function automatic logic load_use_hit(
    input logic                  mem_to_reg,
    input logic [REG_ADDR_W-1:0] rt_ex,
    input logic [REG_ADDR_W-1:0] rs_id,
    input logic [REG_ADDR_W-1:0] rt_id
  );
    return (mem_to_reg == SEL_DMEM) && (rt_ex != '0) &&
           ((rt_ex == rs_id) || (rt_ex == rt_id));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;
  logic         w_full;

  assign w_full = &r_value;
  assign value  = r_value;

  always_ff @(posedge CLK) begin
    if (clear) begin
      r_value <= '0;
    end else if (inc && !w_full) begin
      r_value <= r_value + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: per-cycle hazard priority, halt drain
// sequencing and saturating stall/flush event counters.
module pipeline_ctrl
  import data_path_muxs_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ihit,
  input  logic                  dhit,
  input  logic                  dREN_EX_MEM,
  input  logic                  dWEN_EX_MEM,
  input  logic                  mem_to_reg_ID_EX,
  input  logic [REG_ADDR_W-1:0] Rt_ID_EX,
  input  logic [REG_ADDR_W-1:0] Rs_IF_ID,
  input  logic [REG_ADDR_W-1:0] Rt_IF_ID,
  input  logic                  pc_src_EX,
  input  logic                  halt_EX_MEM,
  input  logic                  halt_MEM_WB,
  output logic                  pc_enable,
  output logic                  enable_IF_ID,
  output logic                  enable_ID_EX,
  output logic                  enable_EX_MEM,
  output logic                  enable_MEM_WB,
  output logic                  flush_IF_ID,
  output logic                  flush_ID_EX,
  output logic                  flush_EX_MEM,
  output logic                  flush_MEM_WB,
  output logic                  halt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;

  logic w_dwait;
  logic w_imiss;
  logic w_branch;
  logic w_loaduse;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_dwait   = (dREN_EX_MEM | dWEN_EX_MEM) & ~dhit;
  assign w_imiss   = ~ihit;
  assign w_branch  = pc_src_EX;
  assign w_loaduse = load_use_hit(mem_to_reg_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Enables report the nominal advance; a register seeing both enable and
  // flush loads the bubble.
  always_comb begin
    w_state_next  = r_state;
    pc_enable     = 1'b1;
    enable_IF_ID  = 1'b1;
    enable_ID_EX  = 1'b1;
    enable_EX_MEM = 1'b1;
    enable_MEM_WB = 1'b1;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    flush_EX_MEM  = 1'b0;
    flush_MEM_WB  = 1'b0;
    halt          = 1'b0;
    w_flush_inc   = 1'b0;

    case (r_state)
      RUN: begin
        if (w_dwait) begin
          pc_enable     = 1'b0;
          enable_IF_ID  = 1'b0;
          enable_ID_EX  = 1'b0;
          enable_EX_MEM = 1'b0;
          flush_MEM_WB  = 1'b1;
        end else if (halt_EX_MEM) begin
          pc_enable    = 1'b0;
          flush_IF_ID  = 1'b1;
          flush_ID_EX  = 1'b1;
          flush_EX_MEM = 1'b1;
          w_state_next = DRAIN;
        end else if (w_imiss) begin
          pc_enable   = 1'b0;
          flush_IF_ID = 1'b1;
        end else if (w_branch) begin
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
          w_flush_inc = 1'b1;
        end else if (w_loaduse) begin
          pc_enable    = 1'b0;
          enable_IF_ID = 1'b0;
          flush_ID_EX  = 1'b1;
        end
      end
      DRAIN: begin
        pc_enable    = 1'b0;
        flush_IF_ID  = 1'b1;
        flush_ID_EX  = 1'b1;
        flush_EX_MEM = 1'b1;
        if (halt_MEM_WB) begin
          w_state_next = HALTED;
        end
      end
      HALTED: begin
        halt          = 1'b1;
        pc_enable     = 1'b0;
        enable_IF_ID  = 1'b0;
        enable_ID_EX  = 1'b0;
        enable_EX_MEM = 1'b0;
        enable_MEM_WB = 1'b0;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  assign w_stall_inc = (r_state == RUN) && !pc_enable;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .clear(RST),
    .inc  (w_stall_inc),
    .value(stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .CLK  (CLK),
    .clear(RST),
    .inc  (w_flush_inc),
    .value(flush_cnt)
  );

endmodule
